parity_check_gen: RTL

- Parametrised successor to the UART-RX parity checker.
- Accumulates a serial data frame of runtime-selectable length, one bit per `sampled_data_valid` strobe, LSB first, then checks the parity bit.
- Supports four parity modes: even, odd, mark, space.
- Reports a per-frame error, a one-cycle done strobe, a sticky error flag and a saturating error counter for the RX status path.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/parity_err_counter.sv | 34 +++
 rtl/parity_check_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART-RX definitions: parity mode codes, checker FSM states and
// the parity verdict used by the checker.
package uart_rx_pkg;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_e;

   // acc is the XOR of all data bits; pbit is the received parity bit.
   function automatic logic parity_bad(input logic [1:0] mode,
                                       input logic       acc,
                                       input logic       pbit);
      case (mode)
         PAR_EVEN: return acc != pbit;
         PAR_ODD:  return acc == pbit;
         PAR_MARK: return !pbit;
         default:  return pbit;
      endcase
   endfunction

endpackage

// File: rtl/parity_err_counter.sv
// Saturating errored-frame counter with sticky flag; a clear coinciding
// with an error counts that error after clearing.
module parity_err_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 asy_reset,
   input  logic                 clk_based_on_prescale,
   input  logic                 i_clear,
   input  logic                 i_inc,
   output logic [CNT_WIDTH-1:0] o_err_count,
   output logic                 o_err_sticky
);

   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_sticky;

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         r_count  <= '0;
         r_sticky <= 1'b0;
      end else if (i_clear) begin
         r_count  <= i_inc ? CNT_WIDTH'(1) : '0;
         r_sticky <= i_inc;
      end else if (i_inc) begin
         if (r_count != '1)
            r_count <= r_count + 1'b1;
         r_sticky <= 1'b1;
      end
   end

   assign o_err_count  = r_count;
   assign o_err_sticky = r_sticky;

endmodule

// File: rtl/parity_check_gen.sv
// Serial parity checker for the UART RX path: accumulates a frame LSB first,
// checks the trailing parity bit and feeds the error statistics.
module parity_check_gen
   import uart_rx_pkg::*;
#(
   parameter int MAX_DATA_WIDTH = 8,
   parameter int LEN_WIDTH      = 4,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                 asy_reset,
   input  logic                 clk_based_on_prescale,
   input  logic                 parity_check_enable,
   input  logic                 sampled_data,
   input  logic                 sampled_data_valid,
   input  logic [1:0]           parity_mode,
   input  logic [LEN_WIDTH-1:0] data_len,
   input  logic                 err_clear,
   output logic                 parity_error,
   output logic                 parity_done,
   output logic                 err_sticky,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_DATA_WIDTH);

   state_e               r_state, w_state_nxt;
   logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
   logic [1:0]           r_mode, w_mode_nxt;
   logic                 r_acc, w_acc_nxt;
   logic                 r_parity_error, w_parity_error_nxt;
   logic                 r_parity_done, w_parity_done_nxt;
   logic                 w_err_evt;
   logic                 w_bad;
   logic [LEN_WIDTH-1:0] w_len_eff;
   logic [LEN_WIDTH-1:0] w_cnt_inc;

   // Zero and out-of-range lengths both mean a full-width frame.
   assign w_len_eff = (data_len == '0 || data_len > MAX_LEN) ? MAX_LEN : data_len;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_bad     = parity_bad(r_mode, r_acc, sampled_data);

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_len          <= '0;
         r_mode         <= PAR_EVEN;
         r_acc          <= 1'b0;
         r_parity_error <= 1'b0;
         r_parity_done  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_len          <= w_len_nxt;
         r_mode         <= w_mode_nxt;
         r_acc          <= w_acc_nxt;
         r_parity_error <= w_parity_error_nxt;
         r_parity_done  <= w_parity_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_len_nxt          = r_len;
      w_mode_nxt         = r_mode;
      w_acc_nxt          = r_acc;
      w_parity_error_nxt = r_parity_error;
      w_parity_done_nxt  = 1'b0;
      w_err_evt          = 1'b0;
      if (!parity_check_enable) begin
         w_state_nxt        = IDLE;
         w_cnt_nxt          = '0;
         w_acc_nxt          = 1'b0;
         w_parity_error_nxt = 1'b0;
      end else if (sampled_data_valid) begin
         case (r_state)
            IDLE: begin
               w_mode_nxt  = parity_mode;
               w_len_nxt   = w_len_eff;
               w_acc_nxt   = sampled_data;
               w_cnt_nxt   = LEN_WIDTH'(1);
               w_state_nxt = (w_len_eff == LEN_WIDTH'(1)) ? PARITY : DATA;
            end
            DATA: begin
               w_acc_nxt = r_acc ^ sampled_data;
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_len)
                  w_state_nxt = PARITY;
            end
            PARITY: begin
               w_parity_error_nxt = w_bad;
               w_parity_done_nxt  = 1'b1;
               w_err_evt          = w_bad;
               w_state_nxt        = IDLE;
               w_cnt_nxt          = '0;
               w_acc_nxt          = 1'b0;
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_acc_nxt   = 1'b0;
            end
         endcase
      end
   end

   parity_err_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_err_cnt (
      .asy_reset             (asy_reset),
      .clk_based_on_prescale (clk_based_on_prescale),
      .i_clear               (err_clear),
      .i_inc                 (w_err_evt),
      .o_err_count           (err_count),
      .o_err_sticky          (err_sticky)
   );

   assign parity_error = r_parity_error;
   assign parity_done  = r_parity_done;

endmodule
